// File: rtl/store_buffer.sv
// FIFO write buffer between the core store port and data memory. Drains one
// entry per ready cycle and forwards the youngest pending store to loads.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     st_valid_i,
   input  logic [ADDR_W-1:0]        st_addr_i,
   input  logic [DATA_W-1:0]        st_data_i,
   output logic                     st_ready_o,
   input  logic [ADDR_W-1:0]        ld_addr_i,
   output logic                     ld_hit_o,
   output logic [DATA_W-1:0]        ld_data_o,
   input  logic                     mem_ready_i,
   output logic                     mem_w_en_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [DATA_W-1:0]        mem_wr_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;
   logic [PTR_W-1:0]  fwd_idx;

   assign st_ready_o = (count_q < CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign mem_w_en_o = !empty_o;
   assign push       = st_valid_i && st_ready_o;
   assign pop        = mem_w_en_o && mem_ready_i;

   assign mem_addr_o    = empty_o ? '0 : addr_q[rd_ptr_q];
   assign mem_wr_data_o = empty_o ? '0 : data_q[rd_ptr_q];

   // Pointer widths equal log2(DEPTH), so the +1 wraps naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: occupancy is governed by count_q alone.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         addr_q[wr_ptr_q] <= st_addr_i;
         data_q[wr_ptr_q] <= st_data_i;
      end
   end

   // Scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      ld_hit_o  = 1'b0;
      ld_data_o = '0;
      fwd_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == ld_addr_i)) begin
            ld_hit_o  = 1'b1;
            ld_data_o = data_q[fwd_idx];
         end
      end
   end

endmodule
